// File: rtl/rps_env_pkg.sv
// ============================================================================
//  Module      : rps_env_pkg
//  Description : Shared types for the rock-paper-scissors match controller:
//                match FSM states, match winner codes and round results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rps_env_pkg;

    // Match controller states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        BUSY  = 3'd2,
        EVAL  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } rps_match_state_e;

    // Encoding of the winner output
    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } rps_winner_e;

    // Outcome of a single evaluated round
    typedef enum logic [1:0] {
        RES_P1  = 2'd0,
        RES_P2  = 2'd1,
        RES_TIE = 2'd2,
        RES_BAD = 2'd3
    } rps_result_e;

endpackage : rps_env_pkg

`default_nettype wire

// File: rtl/rps_round_classify.sv
// ============================================================================
//  Module      : rps_round_classify
//  Description : Combinational round classifier. Compares the running scores
//                against the baseline taken after the previous round; exactly
//                one point to one player (or no points at all) is legal.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rps_round_classify
    import rps_env_pkg::*;
#(
    parameter int SCORE_W = 32
) (
    input  logic [SCORE_W-1:0] score1_i,
    input  logic [SCORE_W-1:0] score2_i,
    input  logic [SCORE_W-1:0] prev1_i,
    input  logic [SCORE_W-1:0] prev2_i,
    output rps_result_e        result_o
);

    localparam logic [SCORE_W-1:0] D_ZERO = '0;
    localparam logic [SCORE_W-1:0] D_ONE  = SCORE_W'(1);

    // Deltas wrap at SCORE_W so a score rolling over still reads as +1
    logic [SCORE_W-1:0] w_d1;
    logic [SCORE_W-1:0] w_d2;

    assign w_d1 = score1_i - prev1_i;
    assign w_d2 = score2_i - prev2_i;

    // Map the delta pair onto a round result; anything else is illegal
    always_comb begin
        result_o = RES_BAD;
        if (w_d1 == D_ONE && w_d2 == D_ZERO) begin
            result_o = RES_P1;
        end else if (w_d1 == D_ZERO && w_d2 == D_ONE) begin
            result_o = RES_P2;
        end else if (w_d1 == D_ZERO && w_d2 == D_ZERO) begin
            result_o = RES_TIE;
        end
    end

endmodule : rps_round_classify

`default_nettype wire

// File: rtl/rps_match_ctrl.sv
// ============================================================================
//  Module      : rps_match_ctrl
//  Description : Best-of-N match controller. Sequences rounds of rps_dut,
//                counts wins/ties/streak, checks score updates for legality,
//                declares the match winner and gates new rounds.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rps_match_ctrl
    import rps_env_pkg::*;
#(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 15,
    parameter int SCORE_W    = 32,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score1,
    input  logic [SCORE_W-1:0] score2,
    input  logic               dut_busy,
    input  logic               match_clr,
    output logic               go_enable,
    output logic [CNT_W-1:0]   round_cnt,
    output logic [CNT_W-1:0]   wins1,
    output logic [CNT_W-1:0]   wins2,
    output logic [CNT_W-1:0]   ties,
    output logic [CNT_W-1:0]   streak,
    output logic               match_done,
    output logic [1:0]         winner,
    output logic               err
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_READY = READY;
    localparam logic [2:0] ST_BUSY  = BUSY;
    localparam logic [2:0] ST_EVAL  = EVAL;
    localparam logic [2:0] ST_DONE  = DONE;
    localparam logic [2:0] ST_ERROR = ERROR;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] WIN_TGT_C = CNT_W'(WIN_TARGET);
    localparam logic [CNT_W-1:0] MAX_RND_C = CNT_W'(MAX_ROUNDS);

    logic [2:0]         state_q,  state_d;
    logic [SCORE_W-1:0] prev1_q,  prev1_d;
    logic [SCORE_W-1:0] prev2_q,  prev2_d;
    logic [CNT_W-1:0]   round_q,  round_d;
    logic [CNT_W-1:0]   wins1_q,  wins1_d;
    logic [CNT_W-1:0]   wins2_q,  wins2_d;
    logic [CNT_W-1:0]   ties_q,   ties_d;
    logic [CNT_W-1:0]   streak_q, streak_d;
    logic [1:0]         winner_q, winner_d;
    logic               err_q,    err_d;
    rps_result_e        last_q,   last_d;    // RES_TIE doubles as "no previous winner"
    rps_result_e        w_res;

    // Counters hold at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    rps_round_classify #(
        .SCORE_W (SCORE_W)
    ) u_classify (
        .score1_i (score1),
        .score2_i (score2),
        .prev1_i  (prev1_q),
        .prev2_i  (prev2_q),
        .result_o (w_res)
    );

    // Next-state, counter and baseline update logic
    always_comb begin
        state_d  = state_q;
        prev1_d  = prev1_q;
        prev2_d  = prev2_q;
        round_d  = round_q;
        wins1_d  = wins1_q;
        wins2_d  = wins2_q;
        ties_d   = ties_q;
        streak_d = streak_q;
        winner_d = winner_q;
        err_d    = err_q;
        last_d   = last_q;

        case (state_q)
            ST_IDLE:  state_d = ST_READY;
            ST_READY: if (dut_busy) state_d = ST_BUSY;
            ST_BUSY:  if (!dut_busy) state_d = ST_EVAL;
            ST_EVAL: begin
                if (w_res == RES_BAD) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    case (w_res)
                        RES_P1: begin
                            wins1_d  = sat_inc(wins1_q);
                            streak_d = (last_q == RES_P1) ? sat_inc(streak_q) : CNT_ONE;
                            last_d   = RES_P1;
                        end
                        RES_P2: begin
                            wins2_d  = sat_inc(wins2_q);
                            streak_d = (last_q == RES_P2) ? sat_inc(streak_q) : CNT_ONE;
                            last_d   = RES_P2;
                        end
                        default: begin
                            ties_d   = sat_inc(ties_q);
                            streak_d = '0;
                            last_d   = RES_TIE;
                        end
                    endcase
                    round_d = sat_inc(round_q);
                    prev1_d = score1;
                    prev2_d = score2;

                    // Termination is judged on the counts including this round
                    if (wins1_d == WIN_TGT_C) begin
                        winner_d = WIN_P1;
                        state_d  = ST_DONE;
                    end else if (wins2_d == WIN_TGT_C) begin
                        winner_d = WIN_P2;
                        state_d  = ST_DONE;
                    end else if (round_d == MAX_RND_C) begin
                        if (wins1_d > wins2_d)      winner_d = WIN_P1;
                        else if (wins2_d > wins1_d) winner_d = WIN_P2;
                        else                        winner_d = WIN_DRAW;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                // New match: clear the tallies, keep err sticky, re-baseline
                if (match_clr) begin
                    state_d  = ST_IDLE;
                    round_d  = '0;
                    wins1_d  = '0;
                    wins2_d  = '0;
                    ties_d   = '0;
                    streak_d = '0;
                    winner_d = WIN_NONE;
                    last_d   = RES_TIE;
                    prev1_d  = score1;
                    prev2_d  = score2;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers; reset also captures the score baseline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            prev1_q  <= score1;
            prev2_q  <= score2;
            round_q  <= '0;
            wins1_q  <= '0;
            wins2_q  <= '0;
            ties_q   <= '0;
            streak_q <= '0;
            winner_q <= WIN_NONE;
            err_q    <= 1'b0;
            last_q   <= RES_TIE;
        end else begin
            state_q  <= state_d;
            prev1_q  <= prev1_d;
            prev2_q  <= prev2_d;
            round_q  <= round_d;
            wins1_q  <= wins1_d;
            wins2_q  <= wins2_d;
            ties_q   <= ties_d;
            streak_q <= streak_d;
            winner_q <= winner_d;
            err_q    <= err_d;
            last_q   <= last_d;
        end
    end

    // go_enable drops as soon as the round starts, before BUSY is registered
    assign go_enable  = (state_q == ST_READY) && !dut_busy;
    assign match_done = (state_q == ST_DONE);
    assign round_cnt  = round_q;
    assign wins1      = wins1_q;
    assign wins2      = wins2_q;
    assign ties       = ties_q;
    assign streak     = streak_q;
    assign winner     = winner_q;
    assign err        = err_q;

endmodule : rps_match_ctrl

`default_nettype wire

// File: doc/rps_match_ctrl.md
Name: rps_match_ctrl

Overview:
- Downstream of rps_dut. Consumes the per-player running scores and dut_busy. Turns individual rounds into a best-of-N match.
- Counts rounds, wins, ties and the current win streak, and checks each score update for legality.
- Declares the match winner and gates further play through go_enable, which the bench ANDs onto go1/go2.

Parameters:
- WIN_TARGET, 3, wins needed to take the match (>=1).
- MAX_ROUNDS, 15, round limit; must be >= 2*WIN_TARGET-1.
- SCORE_W, 32, width of the score inputs (matches int).
- CNT_W, 8, width of the round/win/streak counters.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- score1  in  SCORE_W  player 1 cumulative score from rps_dut.
- score2  in  SCORE_W  player 2 cumulative score from rps_dut.
- dut_busy  in  1  high while rps_dut evaluates a round.
- match_clr  in  1  one-cycle pulse; starts a new match from DONE or ERROR.
- go_enable  out  1  high when a new round may be launched.
- round_cnt  out  CNT_W  rounds evaluated in the current match.
- wins1  out  CNT_W  rounds won by player 1 in the current match.
- wins2  out  CNT_W  rounds won by player 2 in the current match.
- ties  out  CNT_W  tied rounds in the current match.
- streak  out  CNT_W  consecutive wins by the last round winner; 0 after a tie.
- match_done  out  1  high while in DONE.
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=1 at posedge):
  - All counters, match_done, winner and err clear to 0; go_enable=0; state=IDLE.
  - Baselines prev1/prev2 load the current score1/score2.
  - rst has priority over every other input in every state.
- IDLE: one cycle. go_enable=0. Go to READY.
- READY: go_enable=1.
  - dut_busy=1 -> BUSY; go_enable drops in the same cycle, registered one cycle later.
- BUSY: go_enable=0.
  - Waits for dut_busy=0, then goes to EVAL.
  - No timeout.
- EVAL: one cycle. d1=score1-prev1 and d2=score2-prev2, computed at SCORE_W with wrap.
  - d1=1, d2=0: wins1++. streak++ if the previous winner was player 1, else streak=1.
  - d1=0, d2=1: wins2++, with the streak rule mirrored.
  - d1=0, d2=0: ties++, streak=0.
  - Any other delta: err=1 -> ERROR. Counters are not updated.
  - On a legal round: round_cnt++, and prev1/prev2 load score1/score2.
- Termination, evaluated on the post-update counts in EVAL:
  - wins1==WIN_TARGET -> winner=01, DONE.
  - Else wins2==WIN_TARGET -> winner=10, DONE.
  - Else round_cnt==MAX_ROUNDS -> winner = leader, or 11 if wins1==wins2; DONE.
  - Else -> READY.
- DONE: match_done=1, go_enable=0. All outputs hold.
  - match_clr -> IDLE. Counters, streak and winner clear; err unchanged; prev1/prev2 re-baseline.
- ERROR: go_enable=0. Outputs hold.
  - match_clr -> IDLE; err stays 1 until rst.
  - In ERROR, dut_busy activity is ignored.
- Stray inputs:
  - dut_busy=1 while in IDLE, EVAL or DONE is ignored.
  - match_clr outside DONE/ERROR is ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.

Decomposition:
- Shared package rps_env_pkg holds:
  - state enum rps_match_state_e {IDLE, READY, BUSY, EVAL, DONE, ERROR};
  - winner enum rps_winner_e {WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW};
  - round-result enum {RES_P1, RES_P2, RES_TIE, RES_BAD}.
- One sub-module, rps_round_classify: combinational. Maps score1, score2, prev1, prev2 to a round-result value.
- The FSM and counters stay in rps_match_ctrl.

Test Plan:
- Reset with score1=5, score2=7 -> all outputs 0. go_enable=1 on the 2nd cycle after rst deasserts. The first round ending at 6/7 counts as a P1 win.
- Three P1 wins (scores 1/0, 2/0, 3/0), default params -> wins1=3, streak=3, round_cnt=3, winner=01, match_done=1, go_enable=0.
- Alternating P1, P2, tie -> streak 1, 1, 0; ties=1; winner=00 throughout.
- WIN_TARGET=3, MAX_ROUNDS=5; sequence P1, P2, tie, tie, tie -> round_cnt=5, winner=11. Repeat with P1, P1, P2, tie, tie -> winner=01.
- A round where both scores rise by 1 -> err=1, counters unchanged, go_enable=0. match_clr -> counters 0, err still 1. rst clears err.
- rst asserted while in BUSY -> next cycle state IDLE, all counters 0. A later dut_busy fall produces no count.
